// File: rtl/parameters_pkg.sv
// Shared defaults and helpers for the synchronous FIFO.
//   DATA_WIDTH : default word width in bits
//   FIFO_DEPTH : default entry count (power of two, >= 4)
//   ADDR_WIDTH : index width into the storage array for the default depth
//   is_pow2()  : constant function used by the elaboration-time checks
package parameters_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/status bundle between a FIFO user (master) and sync_fifo (slave).
//
// Handshake rules:
//   write side: W_INC is the request and ~FULL is the acceptance; a word on
//     WR_DATA is taken at the CLK edge only when W_INC=1 and FULL=0, and a
//     request made while FULL=1 is dropped and reported by OVERFLOW.
//   read side: R_INC is the request and ~EMPTY is the acceptance; a pop
//     happens at the CLK edge only when R_INC=1 and EMPTY=0, and a request
//     made while EMPTY=1 is dropped and reported by UNDERFLOW. RD_VALID
//     qualifies RD_DATA.
//   CLR flushes the FIFO and overrides both requests in the same cycle.
//
// Signals: CLR, W_INC, WR_DATA, R_INC (master -> slave);
//          RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
//          COUNT, OVERFLOW, UNDERFLOW (slave -> master).
interface sync_fifo_if #(
  parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = parameters_pkg::FIFO_DEPTH
);

  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

  logic                  CLR;
  logic                  W_INC;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  R_INC;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_VALID;
  logic                  FULL;
  logic                  EMPTY;
  logic                  ALMOST_FULL;
  logic                  ALMOST_EMPTY;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output CLR, W_INC, WR_DATA, R_INC,
    input  RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  CLR, W_INC, WR_DATA, R_INC,
    output RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           COUNT, OVERFLOW, UNDERFLOW
  );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo: synchronous write, asynchronous read, no reset.
//   CLK     : clock
//   i_we    : write enable (an accepted write)
//   i_waddr : write index
//   i_wdata : write word
//   i_raddr : read index
//   o_rdata : word stored at i_raddr (combinational)
module fifo_mem #(
  parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
  parameter int DEPTH      = parameters_pkg::FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // Deliberately no reset: contents survive RST and CLR.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, status flags and error pulses.
//   CLK : clock
//   RST : synchronous active-low reset (dominates CLR)
//   bus : sync_fifo_if slave modport (CLR, W_INC, WR_DATA, R_INC in;
//         RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
//         COUNT, OVERFLOW, UNDERFLOW out)
// FWFT=0 : RD_DATA is registered on an accepted read, RD_VALID pulses once.
// FWFT=1 : RD_DATA shows the head word combinationally, RD_VALID = ~EMPTY.
module sync_fifo
  import parameters_pkg::is_pow2;
#(
  parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = parameters_pkg::FIFO_DEPTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  sync_fifo_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CW         = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  // Elaboration-time parameter sanity checks.
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo: FIFO_DEPTH must be a power of two and at least 4");
  end
  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= FIFO_DEPTH)) begin : g_bad_thresh
    $error("sync_fifo: thresholds must satisfy AE_THRESH < AF_THRESH <= FIFO_DEPTH");
  end

  logic [CW-1:0]         r_wptr;
  logic [CW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // Flags come from the registered count, never from the requests.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // CLR wins over both requests in the same cycle.
  assign w_wr_acc = bus.W_INC & ~w_full  & ~bus.CLR;
  assign w_rd_acc = bus.R_INC & ~w_empty & ~bus.CLR;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .CLK     (CLK),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (bus.WR_DATA),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (bus.CLR) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A rejected request is reported on the cycle after it was made.
      r_ovf <= bus.W_INC & w_full;
      r_udf <= bus.R_INC & w_empty;
    end
  end

  // The wrap bit of each pointer makes wptr - rptr the occupancy, which
  // must always agree with the separately maintained count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      assert (r_count == (r_wptr - r_rptr));
    end
  end

  if (!FWFT) begin : g_registered
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge CLK) begin
      if (!RST) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else if (bus.CLR) begin
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        // Hold the last word when no read is accepted.
        if (w_rd_acc) begin
          r_rd_data <= w_mem_rdata;
        end
      end
    end

    assign bus.RD_DATA  = r_rd_data;
    assign bus.RD_VALID = r_rd_valid;
  end else begin : g_fwft
    assign bus.RD_DATA  = w_mem_rdata;
    assign bus.RD_VALID = ~w_empty;
  end

  assign bus.FULL         = w_full;
  assign bus.EMPTY        = w_empty;
  assign bus.ALMOST_FULL  = (r_count >= C_AF);
  assign bus.ALMOST_EMPTY = (r_count <= C_AE);
  assign bus.COUNT        = r_count;
  assign bus.OVERFLOW     = r_ovf;
  assign bus.UNDERFLOW    = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a registered-read instance and an FWFT
// instance share one stimulus stream and one queue-based reference model.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) f0 ();
  sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) f1 ();

  assign f1.CLR     = f0.CLR;
  assign f1.W_INC   = f0.W_INC;
  assign f1.WR_DATA = f0.WR_DATA;
  assign f1.R_INC   = f0.R_INC;

  sync_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (f0.slave)
  );

  sync_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)
  ) u_dut_fwft (
    .CLK (CLK),
    .RST (RST),
    .bus (f1.slave)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is just a queue; error pulses and the
  // registered read word follow from the queue size before each edge.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rd_data  = '0;
  logic          m_rd_valid = 1'b0;
  logic          m_ovf      = 1'b0;
  logic          m_udf      = 1'b0;

  always @(posedge CLK) begin : model
    bit was_full;
    bit was_empty;
    if (!RST) begin
      exp_q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
    end else if (f0.CLR) begin
      exp_q.delete();
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
    end else begin
      was_full   = (exp_q.size() == D);
      was_empty  = (exp_q.size() == 0);
      m_ovf      = f0.W_INC && was_full;
      m_udf      = f0.R_INC && was_empty;
      m_rd_valid = 1'b0;
      if (f0.R_INC && !was_empty) begin
        m_rd_data  = exp_q.pop_front();
        m_rd_valid = 1'b1;
      end
      if (f0.W_INC && !was_full) exp_q.push_back(f0.WR_DATA);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin : compare
    int n;
    if (chk_en) begin
      n = exp_q.size();
      check("count",        32'(f0.COUNT),        32'(n));
      check("full",         32'(f0.FULL),         32'(n == D));
      check("empty",        32'(f0.EMPTY),        32'(n == 0));
      check("almost_full",  32'(f0.ALMOST_FULL),  32'(n >= AF));
      check("almost_empty", 32'(f0.ALMOST_EMPTY), 32'(n <= AE));
      check("overflow",     32'(f0.OVERFLOW),     32'(m_ovf));
      check("underflow",    32'(f0.UNDERFLOW),    32'(m_udf));
      check("rd_valid",     32'(f0.RD_VALID),     32'(m_rd_valid));
      check("rd_data",      32'(f0.RD_DATA),      32'(m_rd_data));
      check("fwft_count",   32'(f1.COUNT),        32'(n));
      check("fwft_ovf",     32'(f1.OVERFLOW),     32'(m_ovf));
      check("fwft_udf",     32'(f1.UNDERFLOW),    32'(m_udf));
      check("fwft_rd_valid", 32'(f1.RD_VALID),    32'(n != 0));
      if (n != 0) check("fwft_rd_data", 32'(f1.RD_DATA), 32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; each call covers one edge.
  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    f0.W_INC   = w;
    f0.WR_DATA = d;
    f0.R_INC   = r;
    f0.CLR     = c;
    @(posedge CLK);
    #1;
    f0.W_INC = 1'b0;
    f0.R_INC = 1'b0;
    f0.CLR   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},     32'(f0.COUNT),        32'd0);
    check({tag, "_empty"},     32'(f0.EMPTY),        32'd1);
    check({tag, "_aempty"},    32'(f0.ALMOST_EMPTY), 32'd1);
    check({tag, "_full"},      32'(f0.FULL),         32'd0);
    check({tag, "_afull"},     32'(f0.ALMOST_FULL),  32'd0);
    check({tag, "_rd_valid"},  32'(f0.RD_VALID),     32'd0);
    check({tag, "_rd_data"},   32'(f0.RD_DATA),      32'd0);
    check({tag, "_ovf"},       32'(f0.OVERFLOW),     32'd0);
    check({tag, "_udf"},       32'(f0.UNDERFLOW),    32'd0);
    check({tag, "_fwft_vld"},  32'(f1.RD_VALID),     32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    f0.CLR     = 1'b0;
    f0.W_INC   = 1'b0;
    f0.WR_DATA = '0;
    f0.R_INC   = 1'b0;
    RST        = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_en = 1'b1;
    check_reset_outputs("reset");
    RST = 1'b1;

    // Fill 0x01..0x08, then one rejected write.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 5) check("af_before_6th", 32'(f0.ALMOST_FULL), 32'd0);
      if (i == 6) check("af_after_6th",  32'(f0.ALMOST_FULL), 32'd1);
    end
    check("full_after_8",  32'(f0.FULL),  32'd1);
    check("count_after_8", 32'(f0.COUNT), 32'd8);
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    check("ovf_pulse",  32'(f0.OVERFLOW), 32'd1);
    check("ovf_count",  32'(f0.COUNT),    32'd8);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_gone",   32'(f0.OVERFLOW), 32'd0);

    // Drain and check order, then one rejected read.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_valid", 32'(f0.RD_VALID), 32'd1);
      check("drain_data",  32'(f0.RD_DATA),  32'(i));
    end
    check("drain_empty", 32'(f0.EMPTY), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_pulse",  32'(f0.UNDERFLOW), 32'd1);
    check("udf_valid",  32'(f0.RD_VALID),  32'd0);

    // Steady state at COUNT=4 across pointer wrap.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 8'(8'h14 + k), 1'b1, 1'b0);
      check("wrap_count", 32'(f0.COUNT),   32'd4);
      check("wrap_data",  32'(f0.RD_DATA), 32'(8'h10 + k));
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_tail", 32'(f0.RD_DATA), 32'(8'h24 + k));
    end

    // Write and read together while empty.
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    check("wr_rd_empty_udf",   32'(f0.UNDERFLOW), 32'd1);
    check("wr_rd_empty_count", 32'(f0.COUNT),     32'd1);
    check("wr_rd_empty_fwft",  32'(f1.RD_DATA),   32'hAA);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("wr_rd_empty_read",  32'(f0.RD_DATA),   32'hAA);
    check("wr_rd_empty_vld",   32'(f0.RD_VALID),  32'd1);

    // CLR beats a concurrent write.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check("pre_clr_count", 32'(f0.COUNT), 32'd5);
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    check("clr_count", 32'(f0.COUNT), 32'd0);
    check("clr_empty", 32'(f0.EMPTY), 32'd1);
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_clr_head", 32'(f0.RD_DATA), 32'h40);

    // Mid-stream reset with CLR and both requests also asserted.
    f0.W_INC = 1'b1; f0.WR_DATA = 8'h55; f0.R_INC = 1'b1; f0.CLR = 1'b1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    f0.W_INC = 1'b0; f0.R_INC = 1'b0; f0.CLR = 1'b0;
    check_reset_outputs("midrst");
    RST = 1'b1;

    // First-word-fall-through instance.
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    check("fwft_data",  32'(f1.RD_DATA),  32'h5A);
    check("fwft_valid", 32'(f1.RD_VALID), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("fwft_hold",  32'(f1.RD_DATA),  32'h5A);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_empty", 32'(f1.EMPTY),    32'd1);
    check("fwft_novld", 32'(f1.RD_VALID), 32'd0);

    // Random traffic: write-heavy first half, read-heavy second half.
    for (int i = 0; i < 600; i++) begin
      int bias;
      logic w, r, c;
      bias = (i < 300) ? 70 : 30;
      w = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) < (100 - bias));
      c = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 249) == 0) RST = 1'b0;
      drive(w, 8'($urandom), r, c);
      RST = 1'b1;
    end

    @(negedge CLK);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
